imem_loader: RTL and testbench

- Byte-stream program loader that fills the CPU's 16-bit instruction memory through its write port. It is the writer counterpart to the CPU's instruction fetch.
- Sits between a host byte link (UART receiver or debug bridge) and the instruction memory write port.
- Holds the CPU in reset until a valid program image has been written.

---
 rtl/imem_loader_if.sv | 47 ++++
 rtl/imem_loader.sv | 249 ++++++++++++++++++++++++
 tb/tb_imem_loader.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
//   Bundles the host byte link and the instruction-memory write port seen by
//   the program loader.
//
//   Signals
//     rx_data   [7:0]            incoming byte from the host link
//     rx_valid                   rx_data is valid
//     rx_ready                   loader accepts the byte this cycle
//     wr_en                      instruction memory write strobe
//     wr_addr   [ADDR_WIDTH-1:0] instruction memory word address
//     wr_data   [15:0]           instruction word to write
//
//   Modports
//     master : the loader (drives rx_ready and the memory write port)
//     slave  : the environment (host byte source plus instruction memory)
// -----------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [15:0]           wr_data;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Byte-stream program loader. Receives a framed program image from a host
//   byte link and writes it word by word into the CPU's 16-bit instruction
//   memory, holding the CPU in reset until a complete image has landed.
//
//   Frame: 0xA5, CNT_HI, CNT_LO, N words (high byte first),
//          [checksum byte when IMEM_LOADER_CHECKSUM_EN is defined]
//
//   Parameters
//     ADDR_WIDTH      word-address width of the instruction memory
//     TIMEOUT_CYCLES  idle cycles tolerated mid-frame before aborting
//
//   Ports
//     clk           system clock
//     reset         asynchronous, active-low reset
//     bus           imem_loader_if.master: rx byte handshake + memory write
//     cpu_hold      CPU reset request, high while no valid image is loaded
//     done          image loaded successfully
//     error         frame aborted (sticky until the next SYNC byte)
//     words_loaded  words written in the current frame
//
//   Optional feature
//     IMEM_LOADER_CHECKSUM_EN  when defined, a trailing byte must equal the
//                              XOR of all 2N data bytes for the frame to
//                              complete; otherwise the frame ends in error.
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_loader_if.master         bus,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int              DEPTH     = 1 << ADDR_WIDTH;
  localparam int              TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]      SYNC_BYTE = 8'hA5;
  localparam logic [ADDR_WIDTH:0]   WORD_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [TMO_W-1:0]      TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t                state;
  logic [7:0]            cnt_hi_byte;
  logic [7:0]            data_hi_byte;
  logic [ADDR_WIDTH:0]   frame_len;
  logic [TMO_W-1:0]      tmo_cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            chk_xor;
`endif

  logic                  accept;
  logic                  waiting_state;
  logic                  sync_seen;
  logic                  is_data_state;
  logic [16:0]           frame_n;
  logic                  count_ok;
  logic                  last_word;

  assign accept = bus.rx_valid && bus.rx_ready;

  // Frame-parsing states that can stall waiting on the host; only these
  // advance the timeout counter.
  always_comb begin
    waiting_state = 1'b0;
    case (state)
      S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO: waiting_state = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:                                    waiting_state = 1'b1;
`endif
      default:                                  waiting_state = 1'b0;
    endcase
  end

  assign sync_seen     = accept && (bus.rx_data == SYNC_BYTE) &&
                         ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign is_data_state = (state == S_DATA_HI) || (state == S_DATA_LO);

  // Word count from the header, widened so counts above DEPTH are visible.
  assign frame_n   = {1'b0, cnt_hi_byte, bus.rx_data};
  assign count_ok  = (frame_n != 17'd0) && (frame_n <= 17'(DEPTH));
  assign last_word = ((words_loaded + WORD_ONE) == frame_len);

  // Byte latches for the header and the pending word. They are only read
  // after being written within the same frame, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept && (state == S_CNT_HI)) begin
      cnt_hi_byte <= bus.rx_data;
    end
    if (accept && (state == S_DATA_HI)) begin
      data_hi_byte <= bus.rx_data;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (sync_seen) begin
      chk_xor <= 8'h00;
    end else if (accept && is_data_state) begin
      chk_xor <= chk_xor ^ bus.rx_data;
    end
`endif
  end

  // Main control FSM; every output is registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      bus.rx_ready <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      frame_len    <= '0;
      tmo_cnt      <= '0;
    end else begin
      bus.wr_en    <= 1'b0;
      bus.rx_ready <= 1'b1;

      // Idle cycles count up while a frame is open; any accepted byte
      // restarts the window.
      if (waiting_state && !accept) begin
        tmo_cnt <= tmo_cnt + TMO_ONE;
      end else begin
        tmo_cnt <= '0;
      end

      if (waiting_state && !accept && (tmo_cnt == TMO_LAST)) begin
        state    <= S_ERR;
        error    <= 1'b1;
        done     <= 1'b0;
        cpu_hold <= 1'b1;
        tmo_cnt  <= '0;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_ERR: begin
            // Anything but SYNC is dropped; SYNC restarts a frame and puts
            // the CPU back in reset even after a successful load.
            if (sync_seen) begin
              state        <= S_CNT_HI;
              cpu_hold     <= 1'b1;
              done         <= 1'b0;
              error        <= 1'b0;
              words_loaded <= '0;
              bus.wr_addr  <= '0;
            end
          end

          S_CNT_HI: begin
            if (accept) begin
              state <= S_CNT_LO;
            end
          end

          S_CNT_LO: begin
            if (accept) begin
              if (count_ok) begin
                frame_len <= frame_n[ADDR_WIDTH:0];
                state     <= S_DATA_HI;
              end else begin
                state    <= S_ERR;
                error    <= 1'b1;
                cpu_hold <= 1'b1;
              end
            end
          end

          S_DATA_HI: begin
            if (accept) begin
              state <= S_DATA_LO;
            end
          end

          S_DATA_LO: begin
            // Issue the write one cycle after the low byte; the link is
            // stalled for exactly that cycle.
            if (accept) begin
              bus.wr_en    <= 1'b1;
              bus.wr_data  <= {data_hi_byte, bus.rx_data};
              bus.rx_ready <= 1'b0;
              state        <= S_WRITE;
            end
          end

          S_WRITE: begin
            // The count check bounds N to DEPTH, so the address can only
            // wrap after the very last word, where it is no longer used.
            bus.wr_addr  <= bus.wr_addr + ADDR_ONE;
            words_loaded <= words_loaded + WORD_ONE;
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= S_CHK;
`else
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
`endif
            end else begin
              state <= S_DATA_HI;
            end
          end

`ifdef IMEM_LOADER_CHECKSUM_EN
          S_CHK: begin
            if (accept) begin
              if (bus.rx_data == chk_xor) begin
                state    <= S_DONE;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
              end else begin
                state    <= S_ERR;
                error    <= 1'b1;
                cpu_hold <= 1'b1;
              end
            end
          end
`endif

          default: begin
            state    <= S_ERR;
            error    <= 1'b1;
            cpu_hold <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Scoreboard bench for imem_loader. Frames are pushed through a reference
//   model that derives the expected memory writes and final status from the
//   frame bytes; a monitor pops expected writes whenever wr_en is seen.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int TMO   = 1024;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .cpu_hold    (cpu_hold),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int  checks   = 0;
  int  failures = 0;
  wr_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%04h, expected no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), e.addr);
        chk("wr_data", 32'(bus.wr_data), e.data);
        chk("rx_ready_in_write", 32'(bus.rx_ready), 0);
      end
    end
  end

  // Reference model: interpret a complete frame. res: 1 = done, 2 = error.
  task automatic model_frame(input bq_t b, output int res, output int words);
    int         n;
    logic [7:0] x;
    wr_t        w;
    n = int'({b[1], b[2]});
    res = 0;
    words = 0;
    if (n == 0 || n > DEPTH) begin
      res = 2;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      w.addr = i;
      w.data = int'({b[3 + 2*i], b[4 + 2*i]});
      exp_q.push_back(w);
      x = x ^ b[3 + 2*i] ^ b[4 + 2*i];
    end
    words = n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    res = (b[3 + 2*n] == x) ? 1 : 2;
`else
    res = 1;
`endif
  endtask

  // Random frame builder; corrupt only matters when the checksum is present.
  task automatic build_frame(input int n, input bit corrupt, output bq_t q);
    logic [7:0] x;
    logic [7:0] d;
    q = {};
    q.push_back(8'hA5);
    q.push_back(8'(n >> 8));
    q.push_back(8'(n));
    x = 8'h00;
    for (int i = 0; i < 2*n; i++) begin
      d = 8'($urandom_range(0, 255));
      q.push_back(d);
      x = x ^ d;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (corrupt) x = x ^ 8'($urandom_range(1, 255));
    q.push_back(x);
`else
    if (corrupt) x = 8'h00;
`endif
  endtask

  // Entry and exit: #1 after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    int guard;
    if (gap > 0) begin
      bus.rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = bus.rx_ready;
      @(posedge clk);
      guard++;
    end
    #1;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL byte_accept_timeout: got no rx_ready in 50 cycles, expected acceptance of 0x%02h", b);
    end
  endtask

  task automatic run_frame(input string name, input bq_t b, input int gap_max);
    int res;
    int words;
    int waited;
    int exp_lat;
    model_frame(b, res, words);
    for (int i = 0; i < b.size(); i++) begin
      send_byte(b[i], $urandom_range(0, gap_max));
      if (i == 0) begin
        chk({name, "_hold_on_sync"}, 32'(cpu_hold), 1);
        chk({name, "_clear_on_sync"}, {30'd0, done, error}, 0);
      end
    end
    bus.rx_valid = 1'b0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(done || error) && waited < 40);
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_lat = 1;
`else
    exp_lat = (res == 1) ? 2 : 1;
`endif
    chk({name, "_latency"}, waited, exp_lat);
    chk({name, "_done"}, 32'(done), (res == 1) ? 1 : 0);
    chk({name, "_error"}, 32'(error), (res == 2) ? 1 : 0);
    chk({name, "_cpu_hold"}, 32'(cpu_hold), (res == 1) ? 0 : 1);
    chk({name, "_words"}, 32'(words_loaded), words);
    #1;
    chk({name, "_drained"}, exp_q.size(), 0);
    exp_q = {};
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f;
    reset        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_hold", 32'(cpu_hold), 1);
    chk("rst_rx_ready", 32'(bus.rx_ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_words", 32'(words_loaded), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_rx_ready", 32'(bus.rx_ready), 1);

    // Nominal two-word image.
    f = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef IMEM_LOADER_CHECKSUM_EN
    f.push_back(8'h40);
`endif
    run_frame("nominal", f, 0);

    // Garbage in DONE is dropped and leaves the loaded image alone.
    send_byte(8'h3C, 1);
    send_byte(8'h77, 0);
    bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("garbage_done", 32'(done), 1);
    chk("garbage_cpu_hold", 32'(cpu_hold), 0);

    // Illegal word counts.
    run_frame("count_zero", {8'hA5, 8'h00, 8'h00}, 1);
    run_frame("count_big", {8'hA5, 8'h04, 8'h01}, 1);

    // Stall mid-frame until the timeout fires at exactly TMO idle cycles.
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    bus.rx_valid = 1'b0;
    repeat (TMO - 1) @(posedge clk);
    @(negedge clk);
    chk("tmo_before", 32'(error), 0);
    @(posedge clk);
    @(negedge clk);
    chk("tmo_error", 32'(error), 1);
    chk("tmo_cpu_hold", 32'(cpu_hold), 1);
    @(posedge clk);
    #1;

    // Valid frame after the abort: error clears on its SYNC.
    build_frame(3, 1'b0, f);
    run_frame("after_tmo", f, 2);

    // Continuous rx_valid: SYNC value inside data is data, held bytes survive.
    f = {8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5};
`ifdef IMEM_LOADER_CHECKSUM_EN
    f.push_back(8'h00);
`endif
    run_frame("mid_sync", f, 0);
    build_frame(4, 1'b0, f);
    run_frame("backpressure", f, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    run_frame("chk_bad", {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h00}, 0);
    run_frame("chk_good", {8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h26}, 0);
`endif

    // Randomized frames with random gaps.
    for (int k = 0; k < 12; k++) begin
      build_frame($urandom_range(1, 6), ($urandom_range(0, 3) == 0), f);
      run_frame("random", f, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
